// File: rtl/genius_pkg.sv
// Shared types and default timing constants for the Genius game blocks.
package genius_pkg;

    typedef logic [3:0] color_t;

    localparam color_t RED    = 4'b0001;
    localparam color_t GREEN  = 4'b0010;
    localparam color_t BLUE   = 4'b0100;
    localparam color_t YELLOW = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SHOW,
        GAP,
        FIN
    } player_state_t;

    localparam int unsigned DEF_SEQ_DEPTH = 32;
    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_T_ON_SLOW = 25_000_000;
    localparam int unsigned DEF_T_ON_FAST = 10_000_000;
    localparam int unsigned DEF_T_GAP     = 5_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/genius_phase_timer.sv
// Loadable down-counter used to time LED on and dark phases.
module genius_phase_timer #(
    parameter int unsigned W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/genius_sequence_player.sv
// Plays the stored colour sequence on the LEDs, one colour per on/gap period.
module genius_sequence_player
    import genius_pkg::*;
#(
    parameter int unsigned SEQ_DEPTH = DEF_SEQ_DEPTH,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned T_ON_SLOW = DEF_T_ON_SLOW,
    parameter int unsigned T_ON_FAST = DEF_T_ON_FAST,
    parameter int unsigned T_GAP     = DEF_T_GAP
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              play,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              speed,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_rdata,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done
);

    localparam int unsigned T_MAX   = max_u(max_u(T_ON_SLOW, T_ON_FAST), T_GAP);
    localparam int unsigned TIMER_W = $clog2(T_MAX + 1);

    localparam logic [TIMER_W-1:0] ON_SLOW_V  = TIMER_W'(T_ON_SLOW);
    localparam logic [TIMER_W-1:0] ON_FAST_V  = TIMER_W'(T_ON_FAST);
    localparam logic [TIMER_W-1:0] GAP_LOAD_V = TIMER_W'(T_GAP - 1);
    localparam logic [ADDR_W:0]    DEPTH_V    = (ADDR_W + 1)'(SEQ_DEPTH);
    localparam logic [ADDR_W:0]    LEN_ONE    = (ADDR_W + 1)'(1);

    player_state_t      state_q, state_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [TIMER_W-1:0] on_ticks_q, on_ticks_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    color_t             colour_q, colour_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_en;
    logic               timer_expired;

    genius_phase_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst_),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .expired  (timer_expired)
    );

    // Next-state logic; settings are captured only when play is accepted in IDLE.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        on_ticks_d     = on_ticks_q;
        index_d        = index_q;
        colour_d       = colour_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (play) begin
                    len_d      = (seq_len > DEPTH_V) ? DEPTH_V : seq_len;
                    on_ticks_d = speed ? ON_FAST_V : ON_SLOW_V;
                    index_d    = '0;
                    state_d    = (len_d == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                // Memory data is valid the cycle after the read strobe.
                colour_d       = mem_rdata;
                timer_load     = 1'b1;
                timer_load_val = on_ticks_q - TIMER_W'(1);
                state_d        = SHOW;
            end
            SHOW: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    timer_load     = 1'b1;
                    timer_load_val = GAP_LOAD_V;
                    state_d        = GAP;
                end
            end
            GAP: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    if ({1'b0, index_q} == (len_q - LEN_ONE)) begin
                        state_d = FIN;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts playback immediately.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q    <= IDLE;
            len_q      <= '0;
            on_ticks_q <= '0;
            index_q    <= '0;
            colour_q   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            on_ticks_q <= on_ticks_d;
            index_q    <= index_d;
            colour_q   <= colour_d;
        end
    end

    // Outputs decode directly from state so reset clears them asynchronously.
    assign mem_rd   = (state_q == FETCH);
    assign mem_addr = index_q;
    assign led      = (state_q == SHOW) ? colour_q : 4'b0000;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);

endmodule

// File: tb/tb_genius_sequence_player.sv
// Bench for genius_sequence_player: per-cycle expected output trace built from
// the playback rules, compared by an independent monitor on the falling edge.
module tb_genius_sequence_player;

    localparam int T_ON_SLOW = 4;
    localparam int T_ON_FAST = 2;
    localparam int T_GAP     = 2;
    localparam int DEPTH     = 32;
    localparam int W         = 12; // {mem_rd, mem_addr[4:0], led[3:0], busy, done}

    logic       clk;
    logic       rst_;
    logic       play;
    logic [5:0] seq_len;
    logic       speed;
    logic       mem_rd;
    logic [4:0] mem_addr;
    logic [3:0] mem_rdata;
    logic [3:0] led;
    logic       busy;
    logic       done;

    logic [3:0]   mem [DEPTH];
    logic [W-1:0] exp_q[$];
    int           cyc;
    int           last_busy;
    int           n_tests;
    int           n_fail;
    logic         started;

    genius_sequence_player #(
        .SEQ_DEPTH (32),
        .ADDR_W    (5),
        .T_ON_SLOW (T_ON_SLOW),
        .T_ON_FAST (T_ON_FAST),
        .T_GAP     (T_GAP)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .play      (play),
        .seq_len   (seq_len),
        .speed     (speed),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Sequence memory: read data valid one cycle after the strobe.
    initial mem_rdata = 4'h0;
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] mk(input logic rd, input logic [4:0] a,
                                        input logic [3:0] l, input logic b, input logic d);
        return {rd, a, l, b, d};
    endfunction

    // Expected outputs for every cycle from the one after play up to done.
    task automatic push_trace(input int n, input int on);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(1'b1, 5'(i), 4'h0, 1'b1, 1'b0));
            exp_q.push_back(mk(1'b0, 5'h0, 4'h0, 1'b1, 1'b0));
            for (int t = 0; t < on; t++) exp_q.push_back(mk(1'b0, 5'h0, mem[i], 1'b1, 1'b0));
            for (int t = 0; t < T_GAP; t++) exp_q.push_back(mk(1'b0, 5'h0, 4'h0, 1'b1, 1'b0));
        end
        exp_q.push_back(mk(1'b0, 5'h0, 4'h0, 1'b1, 1'b1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One-cycle play pulse; the model decides whether the player was idle.
    task automatic pulse_play(input int len, input logic spd);
        int n;
        int on;
        seq_len = 6'(len);
        speed   = spd;
        play    = 1'b1;
        @(posedge clk);
        #1;
        play = 1'b0;
        if (!rst_ && (cyc > last_busy)) begin
            n  = (len > DEPTH) ? DEPTH : len;
            on = spd ? T_ON_FAST : T_ON_SLOW;
            push_trace(n, on);
            last_busy = cyc + n * (2 + on + T_GAP) + 1;
        end
    endtask

    // Runs until the model says playback is over, optionally disturbing inputs.
    task automatic wait_done(input logic noisy);
        while (cyc <= last_busy) begin
            if (noisy && ($urandom_range(0, 2) == 0)) begin
                pulse_play($urandom_range(0, 40), 1'($urandom_range(0, 1)));
            end else begin
                if (noisy) begin
                    seq_len = 6'($urandom_range(0, 40));
                    speed   = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                #1;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #3;
        rst_ = 1'b1;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_mem_rd", 32'(mem_rd), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        exp_q.delete();
        last_busy = cyc;
        repeat (2) @(posedge clk);
        #3;
        rst_ = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic load_directed();
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[0] = 4'b0001;
        mem[1] = 4'b0100;
        mem[2] = 4'b1000;
    endtask

    task automatic load_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] expv;
        logic [W-1:0] act;
        logic [W-1:0] mask;
        if (started && !rst_) begin
            expv = (exp_q.size() != 0) ? exp_q.pop_front() : mk(1'b0, 5'h0, 4'h0, 1'b0, 1'b0);
            act  = {mem_rd, mem_addr, led, busy, done};
            // The address only matters while the read strobe is expected.
            mask = expv[W-1] ? {W{1'b1}} : {1'b1, 5'h00, 6'h3f};
            n_tests++;
            if ((act & mask) !== (expv & mask)) begin
                n_fail++;
                $display("FAIL trace cycle %0d: rd/addr/led/busy/done got %b expected %b",
                         cyc, act & mask, expv & mask);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests   = 0;
        n_fail    = 0;
        started   = 1'b0;
        last_busy = -1;
        rst_      = 1'b1;
        play      = 1'b0;
        seq_len   = '0;
        speed     = 1'b0;
        load_directed();
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_    = 1'b0;
        started = 1'b1;
        @(posedge clk);
        #1;

        // Three colours, slow then fast.
        pulse_play(3, 1'b0);
        wait_done(1'b0);
        pulse_play(3, 1'b1);
        wait_done(1'b0);

        // Empty sequence: straight to done, no reads.
        pulse_play(0, 1'b0);
        wait_done(1'b0);

        // Oversized length clamps to the full memory.
        load_random();
        pulse_play(40, 1'($urandom_range(0, 1)));
        wait_done(1'b0);

        // Extra play pulses and setting changes while busy are ignored.
        load_directed();
        pulse_play(3, 1'b0);
        wait_done(1'b1);

        // Reset during the second colour's on-phase, then a clean restart.
        pulse_play(3, 1'b0);
        repeat (10) @(posedge clk);
        apply_reset();
        pulse_play(3, 1'b0);
        wait_done(1'b0);

        // Randomised sequences.
        for (int r = 0; r < 12; r++) begin
            load_random();
            pulse_play($urandom_range(0, 36), 1'($urandom_range(0, 1)));
            wait_done(1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("trace_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
